// File: rtl/shift_deser.sv
// shift_deser: serial-in/parallel-out receiver with a valid/ack output holding register.
// Rebuilds N-bit words from an MSB-first or LSB-first bit stream. A completed word waits
// in Qout while the next frame shifts in; a word that completes while Qout is still
// unconsumed is dropped and flagged on the sticky Ovr output.
// Optional build macro PARITY_CHECK_EN: each frame carries an extra trailing even-parity bit
// that is checked into Perr. Without it, frames are N bits long and Perr is tied low.
module shift_deser #(
  parameter int unsigned N = 4
) (
  input  logic       CLK,
  input  logic       clr_n,
  input  logic       Sin,
  input  logic       Sen,
  input  logic       Start,
  input  logic       Lshift,
  input  logic       Ack,
  input  logic       Ovr_clr,
  output logic [N:1] Qout,
  output logic       Dvalid,
  output logic       Ovr,
  output logic       Ferr,
  output logic       Perr
);

`ifdef PARITY_CHECK_EN
  localparam int unsigned L = N + 1;
`else
  localparam int unsigned L = N;
`endif
  localparam int unsigned CW = $clog2(L + 1);
  localparam logic [CW-1:0] LCnt   = CW'(L);
  localparam logic [CW-1:0] NCnt   = CW'(N);
  localparam logic [CW-1:0] OneCnt = CW'(1);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [N:1]    r_shift, w_shift_nxt;
  logic          r_dir, w_dir_nxt;
  logic [N:1]    r_qout, w_qout_nxt;
  logic          r_dvalid, w_dvalid_nxt;
  logic          r_ovr, w_ovr_nxt;
  logic          r_ferr, w_ferr_nxt;

  logic          w_start;
  logic          w_bit;
  logic          w_shift_en;
  logic          w_done;
  logic          w_load;
  logic [N:1]    w_shifted;

`ifdef PARITY_CHECK_EN
  logic          r_par, w_par_nxt;
  logic          r_perr, w_perr_nxt;
`endif

  // Next-state logic for the receive FSM, shifter, counter and output handshake
  always_comb begin
    w_start     = Sen & Start;
    // A bit is accepted on any strobe in RECV, or on a Start strobe in IDLE
    w_bit       = Sen & (w_start | (r_state == StRecv));
    w_dir_nxt   = w_start ? Lshift : r_dir;
    // Only the first N bits of a frame are data; a trailing parity bit is not shifted
    w_shift_en  = w_bit & (w_start | (r_cnt < NCnt));
    w_shifted   = w_dir_nxt ? {r_shift[N-1:1], Sin} : {Sin, r_shift[N:2]};
    w_shift_nxt = w_shift_en ? w_shifted : r_shift;
    w_done      = w_bit & ~w_start & ((r_cnt + OneCnt) == LCnt);
    // A completed word is accepted if the holding register is free or being consumed now
    w_load      = w_done & (~r_dvalid | Ack);

    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_start) begin
      w_state_nxt = StRecv;
      w_cnt_nxt   = OneCnt;
    end else if (w_done) begin
      w_state_nxt = StIdle;
      w_cnt_nxt   = '0;
    end else if (w_bit) begin
      w_cnt_nxt   = r_cnt + OneCnt;
    end

    w_ferr_nxt   = w_start & (r_state == StRecv);

    w_qout_nxt   = r_qout;
    w_dvalid_nxt = r_dvalid;
    // Clear first so that a same-edge overrun set takes priority
    w_ovr_nxt    = r_ovr & ~Ovr_clr;
    if (w_done) begin
      if (w_load) begin
        w_qout_nxt   = w_shift_nxt;
        w_dvalid_nxt = 1'b1;
      end else begin
        w_ovr_nxt    = 1'b1;
      end
    end else if (Ack) begin
      w_dvalid_nxt = 1'b0;
    end

`ifdef PARITY_CHECK_EN
    w_par_nxt  = r_par;
    if (w_shift_en) begin
      w_par_nxt = (w_start ? 1'b0 : r_par) ^ Sin;
    end
    // Perr tracks the word in Qout, so it only changes when Qout is loaded
    w_perr_nxt = r_perr;
    if (w_load) begin
      w_perr_nxt = r_par ^ Sin;
    end
`endif
  end

  // Receive FSM state register
  always_ff @(posedge CLK) begin
    if (!clr_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath, counter and handshake registers
  always_ff @(posedge CLK) begin
    if (!clr_n) begin
      r_cnt    <= '0;
      r_shift  <= '0;
      r_dir    <= 1'b0;
      r_qout   <= '0;
      r_dvalid <= 1'b0;
      r_ovr    <= 1'b0;
      r_ferr   <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_par    <= 1'b0;
      r_perr   <= 1'b0;
`endif
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_dir    <= w_dir_nxt;
      r_qout   <= w_qout_nxt;
      r_dvalid <= w_dvalid_nxt;
      r_ovr    <= w_ovr_nxt;
      r_ferr   <= w_ferr_nxt;
`ifdef PARITY_CHECK_EN
      r_par    <= w_par_nxt;
      r_perr   <= w_perr_nxt;
`endif
    end
  end

  assign Qout   = r_qout;
  assign Dvalid = r_dvalid;
  assign Ovr    = r_ovr;
  assign Ferr   = r_ferr;
`ifdef PARITY_CHECK_EN
  assign Perr   = r_perr;
`else
  assign Perr   = 1'b0;
`endif

endmodule
